keypad_emulator: RTL and testbench
==================================

Name: keypad_emulator

Overview:
- Drives the row lines of a 4x4 matrix keypad in response to the column scan, acting as the keypad end of the scan interface.
- Accepts a 4-bit key code through a valid/ready handshake and "presses" that key for a programmable time, with optional contact-bounce emulation.
- Used as a loopback/self-test source feeding the keypad scanner input, and as a synthesizable stimulus block on the test board.

Parameters:
PRESS_CYCLES, 2000000, clean-contact hold time in clk cycles (>=1)
BOUNCE_CYCLES, 65536, length of each bounce window (press and release) in clk cycles (>=1)
GAP_CYCLES, 1048576, released time after a key before the next key is accepted (>=1)
LFSR_SEED, 16'hACE1, nonzero reset seed of the bounce LFSR

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high; sampled on rising edge of clk
columnas  input  4  column drive from scanner, one-hot active-high; bit 3 = column 0
key_code  input  4  key to press; same code map the scanner produces
key_valid  input  1  key_code valid
key_ready  output  1  block can accept a key
filas  output  4  row lines to scanner, active-high; bit 3 = row 0
busy  output  1  high from acceptance until done
done  output  1  one-cycle pulse when key sequence finishes
err  output  1  one-cycle pulse (with done) for unmappable code

Behaviour:
- Reset: state IDLE, counter 0, LFSR=LFSR_SEED, filas=4'b0000, key_ready=0 during reset cycle then 1, busy=0, done=0, err=0. Reset mid-sequence aborts: filas=0 the cycle after reset is sampled.
- Code map (code -> column,row): 1->0,0; 2->1,0; 3->2,0; A->3,0; 4->0,1; 5->1,1; 6->2,1; B->3,1; 7->0,2; 8->1,2; 9->2,2; C->3,2; D->0,3; 0->1,3; E->2,3; F -> unmappable. Column c uses columnas[3-c], row r drives filas[3-r].
- Handshake: key_ready=1 only in IDLE. Transfer when key_valid&key_ready on a clk edge; key_code latched. key_valid may stay high; no second transfer until IDLE again.
- Code F: no press. Next cycle done=1, err=1; block returns to IDLE (key_ready=1 that same cycle).
- FSM: IDLE -> BOUNCE_IN (BOUNCE_CYCLES) -> HOLD (PRESS_CYCLES) -> BOUNCE_OUT (BOUNCE_CYCLES) -> GAP (GAP_CYCLES) -> IDLE. Single down-counter sized by $clog2 of the largest parameter, loaded on entry, transition when counter reaches 1.
- contact: 0 in IDLE/GAP, 1 in HOLD, LFSR bit 0 in BOUNCE_IN/BOUNCE_OUT. LFSR (16-bit Fibonacci, taps 16,14,13,11) advances every cycle only in bounce states.
- filas registered, 1-cycle latency: filas[3-r] <= contact & columnas[3-c]; all other bits 0. Multiple columnas bits high is legal; only the latched column matters.
- done asserted in the cycle state re-enters IDLE; busy=1 in every non-IDLE state.
- Accept-to-done latency for a valid key = 2*BOUNCE_CYCLES + PRESS_CYCLES + GAP_CYCLES + 1 cycles.

Optional Feature:
- KEYPAD_BOUNCE_EN defined: bounce states and LFSR as above.
- Not defined: BOUNCE_IN/BOUNCE_OUT omitted (IDLE -> HOLD -> GAP), LFSR not instantiated; latency = PRESS_CYCLES + GAP_CYCLES + 1.

Decomposition:
- Package keypad_pkg: state enum (IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP), key code constants (KEY_0..KEY_F, KEY_NONE=4'hF), function mapping code -> {col,row,valid}; shared with the scanner.
- One sub-module: bounce_lfsr (enable, seed, 1-bit output).

Test Plan (PRESS_CYCLES=16, BOUNCE_CYCLES=4, GAP_CYCLES=8, scanner columnas rotating 8 cycles per column):
- Reset then key_code=5 valid: key_ready drops next cycle; in HOLD with columnas=4'b0100 filas=4'b0100, with columnas=4'b1000 filas=4'b0000; done pulse 33 cycles after acceptance.
- key_code=E: filas=4'b0001 only while columnas=4'b0010 in HOLD; loopback through scanner yields sample=4'b1110.
- key_code=F: done=1 and err=1 next cycle, filas stays 0, key_ready=1 that cycle.
- key_valid held high with codes 1 then 2: second transfer only after done; filas=4'b1000 for both, column 1000 then 0100.
- Reset asserted in HOLD of key 8: filas=0, busy=0, key_ready=1 cycle after reset deasserts.
- With KEYPAD_BOUNCE_EN: filas toggles within BOUNCE_IN matching LFSR from seed 16'hACE1; without: no toggling, done 25 cycles after acceptance.

Source files
------------

// File: rtl/keypad_pkg.sv
// ============================================================================
// Module  : keypad_pkg
// Purpose : Shared keypad state encoding, key codes and code-to-position map.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOUNCE_IN  = 3'd1,
    HOLD       = 3'd2,
    BOUNCE_OUT = 3'd3,
    GAP        = 3'd4
  } kp_state_t;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_E    = 4'hE;
  localparam logic [3:0] KEY_F    = 4'hF;
  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef struct packed {
    logic [1:0] col;
    logic [1:0] row;
    logic       valid;
  } key_pos_t;

  // Matrix position of a key; F has no physical key and reports valid=0.
  function automatic key_pos_t key_map(input logic [3:0] code);
    key_pos_t pos;
    pos = '{col: 2'd0, row: 2'd0, valid: 1'b0};
    case (code)
      KEY_1: pos = '{col: 2'd0, row: 2'd0, valid: 1'b1};
      KEY_2: pos = '{col: 2'd1, row: 2'd0, valid: 1'b1};
      KEY_3: pos = '{col: 2'd2, row: 2'd0, valid: 1'b1};
      KEY_A: pos = '{col: 2'd3, row: 2'd0, valid: 1'b1};
      KEY_4: pos = '{col: 2'd0, row: 2'd1, valid: 1'b1};
      KEY_5: pos = '{col: 2'd1, row: 2'd1, valid: 1'b1};
      KEY_6: pos = '{col: 2'd2, row: 2'd1, valid: 1'b1};
      KEY_B: pos = '{col: 2'd3, row: 2'd1, valid: 1'b1};
      KEY_7: pos = '{col: 2'd0, row: 2'd2, valid: 1'b1};
      KEY_8: pos = '{col: 2'd1, row: 2'd2, valid: 1'b1};
      KEY_9: pos = '{col: 2'd2, row: 2'd2, valid: 1'b1};
      KEY_C: pos = '{col: 2'd3, row: 2'd2, valid: 1'b1};
      KEY_D: pos = '{col: 2'd0, row: 2'd3, valid: 1'b1};
      KEY_0: pos = '{col: 2'd1, row: 2'd3, valid: 1'b1};
      KEY_E: pos = '{col: 2'd2, row: 2'd3, valid: 1'b1};
      default: pos = '{col: 2'd0, row: 2'd0, valid: 1'b0};
    endcase
    return pos;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bounce_lfsr.sv
// ============================================================================
// Module  : bounce_lfsr
// Purpose : 16-bit Fibonacci LFSR (taps 16,14,13,11) producing contact bounce.
//           Only built when KEYPAD_BOUNCE_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef KEYPAD_BOUNCE_EN
module bounce_lfsr (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic        bit_out
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign bit_out = r_lfsr[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= seed;
    end else if (enable) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/keypad_emulator.sv
// ============================================================================
// Module  : keypad_emulator
// Purpose : Keypad-side emulation of a 4x4 matrix: presses a handshaken key
//           code on the row lines. Contact bounce enabled by KEYPAD_BOUNCE_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int          PRESS_CYCLES  = 2000000,
  parameter int          BOUNCE_CYCLES = 65536,
  parameter int          GAP_CYCLES    = 1048576,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] columnas,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic [3:0] filas,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int c_MAX_PB = (PRESS_CYCLES > BOUNCE_CYCLES) ? PRESS_CYCLES : BOUNCE_CYCLES;
  localparam int c_MAX    = (c_MAX_PB > GAP_CYCLES) ? c_MAX_PB : GAP_CYCLES;
  localparam int c_CNT_W  = $clog2(c_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_PRESS  = c_CNT_W'(PRESS_CYCLES);
  localparam logic [c_CNT_W-1:0] c_GAP    = c_CNT_W'(GAP_CYCLES);
  localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);
`ifdef KEYPAD_BOUNCE_EN
  localparam logic [c_CNT_W-1:0] c_BOUNCE = c_CNT_W'(BOUNCE_CYCLES);
`endif

  kp_state_t           r_state, w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [1:0]          r_col, r_row;
  logic [3:0]          r_filas;
  logic                r_done, r_err;
  logic                w_done_nxt, w_err_nxt;
  logic                w_accept, w_contact;
  logic                w_last;
  key_pos_t            w_map;

`ifdef KEYPAD_BOUNCE_EN
  logic w_lfsr_en;
  logic w_lfsr_bit;

  bounce_lfsr u_bounce_lfsr (
    .clk     (clk),
    .reset   (reset),
    .enable  (w_lfsr_en),
    .seed    (LFSR_SEED),
    .bit_out (w_lfsr_bit)
  );
`endif

  assign w_map     = key_map(key_code);
  assign w_last    = (r_cnt == c_ONE);
  assign key_ready = (r_state == IDLE) && !reset;
  assign busy      = (r_state != IDLE);
  assign filas     = r_filas;
  assign done      = r_done;
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_col   <= 2'd0;
      r_row   <= 2'd0;
      r_filas <= 4'b0000;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (w_accept) begin
        r_col <= w_map.col;
        r_row <= w_map.row;
      end
      // Bit index 3-n of a 2-bit position is simply its complement.
      r_filas <= 4'b0000;
      if (w_contact && columnas[~r_col]) begin
        r_filas[~r_row] <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_accept    = 1'b0;
    w_contact   = 1'b0;
`ifdef KEYPAD_BOUNCE_EN
    w_lfsr_en   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (key_valid) begin
          if (!w_map.valid) begin
            w_done_nxt = 1'b1;
            w_err_nxt  = 1'b1;
          end else begin
            w_accept = 1'b1;
`ifdef KEYPAD_BOUNCE_EN
            w_state_nxt = BOUNCE_IN;
            w_cnt_nxt   = c_BOUNCE;
`else
            w_state_nxt = HOLD;
            w_cnt_nxt   = c_PRESS;
`endif
          end
        end
      end
`ifdef KEYPAD_BOUNCE_EN
      BOUNCE_IN: begin
        w_contact = w_lfsr_bit;
        w_lfsr_en = 1'b1;
        if (w_last) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = c_PRESS;
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
`endif
      HOLD: begin
        w_contact = 1'b1;
        if (w_last) begin
`ifdef KEYPAD_BOUNCE_EN
          w_state_nxt = BOUNCE_OUT;
          w_cnt_nxt   = c_BOUNCE;
`else
          w_state_nxt = GAP;
          w_cnt_nxt   = c_GAP;
`endif
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
`ifdef KEYPAD_BOUNCE_EN
      BOUNCE_OUT: begin
        w_contact = w_lfsr_bit;
        w_lfsr_en = 1'b1;
        if (w_last) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = c_GAP;
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
`endif
      GAP: begin
        if (w_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_emulator.sv
// ============================================================================
// Module  : tb_keypad_emulator
// Purpose : Directed self-checking bench for keypad_emulator (short timings).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_keypad_emulator;

`ifdef KEYPAD_BOUNCE_EN
  localparam int BIN = 4;
  localparam int LAT = 33;
`else
  localparam int BIN = 0;
  localparam int LAT = 25;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] columnas;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] filas;
  logic       busy;
  logic       done;
  logic       err;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keypad_emulator #(
    .PRESS_CYCLES  (16),
    .BOUNCE_CYCLES (4),
    .GAP_CYCLES    (8),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .columnas  (columnas),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .filas     (filas),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task tick();
    @(posedge clk);
    #1;
  endtask

  task ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task wait_done(output int t);
    t = -1000;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) begin
        t = cyc;
        break;
      end
      tick();
    end
  endtask

  int t_acc;
  int t_done;
`ifdef KEYPAD_BOUNCE_EN
  logic [15:0] m;
`endif

  initial begin
    reset     = 1'b1;
    columnas  = 4'b0000;
    key_code  = 4'h0;
    key_valid = 1'b0;

    // Reset state
    ticks(3);
    chk("rst_ready", key_ready, 1'b0);
    chk("rst_filas", filas, 4'b0000);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_done",  done, 1'b0);
    chk("rst_err",   err, 1'b0);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", key_ready, 1'b1);

    // Key 5: column 1 (0100), row 1 (filas 0100)
    key_code = 4'h5; key_valid = 1'b1; columnas = 4'b0100;
    t_acc = cyc;
    tick();
    key_valid = 1'b0;
    chk("k5_ready_drop", key_ready, 1'b0);
    chk("k5_busy", busy, 1'b1);
    ticks(BIN + 4);
    chk("k5_hold_col1", filas, 4'b0100);
    columnas = 4'b1000;
    tick();
    chk("k5_hold_col0", filas, 4'b0000);
    columnas = 4'b0100;
    tick();
    chk("k5_hold_col1b", filas, 4'b0100);
    wait_done(t_done);
    chk("k5_latency", t_done - t_acc, LAT);
    chk("k5_err", err, 1'b0);
    chk("k5_done_ready", key_ready, 1'b1);
    chk("k5_done_filas", filas, 4'b0000);

    // Key E: column 2 (0010), row 3 (filas 0001)
    key_code = 4'hE; key_valid = 1'b1; columnas = 4'b0010;
    t_acc = cyc;
    tick();
    key_valid = 1'b0;
    ticks(BIN + 4);
    chk("kE_hold_col2", filas, 4'b0001);
    columnas = 4'b0100;
    tick();
    chk("kE_hold_col1", filas, 4'b0000);
    columnas = 4'b1111;
    tick();
    chk("kE_hold_all", filas, 4'b0001);
    wait_done(t_done);
    chk("kE_latency", t_done - t_acc, LAT);
    tick();
    chk("kE_done_clear", done, 1'b0);

    // Key F: unmappable
    key_code = 4'hF; key_valid = 1'b1; columnas = 4'b1000;
    tick();
    key_valid = 1'b0;
    chk("kF_done", done, 1'b1);
    chk("kF_err", err, 1'b1);
    chk("kF_ready", key_ready, 1'b1);
    chk("kF_filas", filas, 4'b0000);
    chk("kF_busy", busy, 1'b0);
    tick();
    chk("kF_done_clear", done, 1'b0);
    chk("kF_err_clear", err, 1'b0);

    // key_valid held high: key 1 then key 2
    key_code = 4'h1; key_valid = 1'b1; columnas = 4'b1000;
    t_acc = cyc;
    tick();
    key_code = 4'h2;
    chk("k1_ready_drop", key_ready, 1'b0);
    ticks(BIN + 4);
    chk("k1_hold", filas, 4'b1000);
    chk("k1_no_retransfer", key_ready, 1'b0);
    wait_done(t_done);
    chk("k1_latency", t_done - t_acc, LAT);
    chk("k1_done_ready", key_ready, 1'b1);
    columnas = 4'b0100;
    t_acc = cyc;
    tick();
    key_valid = 1'b0;
    chk("k2_busy", busy, 1'b1);
    ticks(BIN + 4);
    chk("k2_hold", filas, 4'b1000);
    columnas = 4'b1000;
    tick();
    chk("k2_hold_col0", filas, 4'b0000);
    wait_done(t_done);
    chk("k2_latency", t_done - t_acc, LAT);

    // Key 8 aborted by reset in HOLD: column 1, row 2 (filas 0010)
    tick();
    key_code = 4'h8; key_valid = 1'b1; columnas = 4'b0100;
    tick();
    key_valid = 1'b0;
    ticks(BIN + 4);
    chk("k8_hold", filas, 4'b0010);
    reset = 1'b1;
    tick();
    chk("k8_rst_filas", filas, 4'b0000);
    chk("k8_rst_busy", busy, 1'b0);
    chk("k8_rst_ready", key_ready, 1'b0);
    reset = 1'b0;
    tick();
    chk("k8_post_ready", key_ready, 1'b1);
    chk("k8_post_busy", busy, 1'b0);
    chk("k8_post_filas", filas, 4'b0000);
    ticks(3);
    chk("k8_post_done", done, 1'b0);

`ifdef KEYPAD_BOUNCE_EN
    // Bounce pattern on entry, LFSR freshly reseeded by the reset above
    key_code = 4'h5; key_valid = 1'b1; columnas = 4'b0100;
    t_acc = cyc;
    tick();
    key_valid = 1'b0;
    m = 16'hACE1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bounce_in", filas, m[0] ? 4'b0100 : 4'b0000);
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end
    wait_done(t_done);
    chk("bounce_latency", t_done - t_acc, LAT);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
